// File: rtl/decode_if.sv
// Signal bundle between the fetch/hazard/write-back side and the decode stage.
// Signal names follow the original decode_stage port list.
interface decode_if;
  logic [31:0] PC_in;
  logic [31:0] Instruction_in;
  logic [3:0]  SR;
  logic        hazard;
  logic        flush;
  logic        WB_en_in;
  logic [3:0]  WB_dest;
  logic [31:0] WB_value;

  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        Two_src;

  logic [31:0] PC_out;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest;
  logic [3:0]  EXE_CMD;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        WB_EN;
  logic        B;
  logic        S;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;

  modport master (
    output PC_in, Instruction_in, SR, hazard, flush, WB_en_in, WB_dest, WB_value,
    input  src1, src2, Two_src,
    input  PC_out, Val_Rn, Val_Rm, Dest, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN,
    input  B, S, imm, Shift_operand, Signed_imm_24
  );

  modport slave (
    input  PC_in, Instruction_in, SR, hazard, flush, WB_en_in, WB_dest, WB_value,
    output src1, src2, Two_src,
    output PC_out, Val_Rn, Val_Rm, Dest, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN,
    output B, S, imm, Shift_operand, Signed_imm_24
  );
endinterface

// File: rtl/decode_stage.sv
// ARM-style instruction decode stage: register file with write bypass,
// condition evaluation, control decode and the ID/EX pipeline register.
module decode_stage (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);

  logic [31:0] regs [15];

  logic [3:0]  cond;
  logic [1:0]  mode;
  logic        i_bit;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [3:0]  rm;
  logic        is_str;

  assign cond   = bus.Instruction_in[31:28];
  assign mode   = bus.Instruction_in[27:26];
  assign i_bit  = bus.Instruction_in[25];
  assign opcode = bus.Instruction_in[24:21];
  assign s_bit  = bus.Instruction_in[20];
  assign rn     = bus.Instruction_in[19:16];
  assign rd     = bus.Instruction_in[15:12];
  assign rm     = bus.Instruction_in[3:0];
  assign is_str = (mode == 2'b01) && !s_bit;

  assign bus.src1    = rn;
  assign bus.src2    = is_str ? rd : rm;
  assign bus.Two_src = !i_bit || is_str;

  logic wb_write;
  assign wb_write = bus.WB_en_in && (bus.WB_dest != 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.WB_dest] <= bus.WB_value;
    end
  end

  // R15 is not stored and always reads zero; the bypass never targets it.
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  always_comb begin
    val_rn = '0;
    val_rm = '0;
    if (rn != 4'd15) val_rn = (wb_write && bus.WB_dest == rn) ? bus.WB_value : regs[rn];
    if (bus.src2 != 4'd15) val_rm = (wb_write && bus.WB_dest == bus.src2) ? bus.WB_value : regs[bus.src2];
  end

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = bus.SR;

  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  logic [3:0] exe_cmd;
  logic       mem_r, mem_w, wb_en, br, s_out;
  always_comb begin
    exe_cmd = '0;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    wb_en   = 1'b0;
    br      = 1'b0;
    s_out   = 1'b0;
    case (mode)
      2'b00: begin
        s_out = s_bit;
        wb_en = 1'b1;
        case (opcode)
          4'b1101: exe_cmd = 4'b0001;
          4'b1111: exe_cmd = 4'b1001;
          4'b0100: exe_cmd = 4'b0010;
          4'b0101: exe_cmd = 4'b0011;
          4'b0010: exe_cmd = 4'b0100;
          4'b0110: exe_cmd = 4'b0101;
          4'b0000: exe_cmd = 4'b0110;
          4'b1100: exe_cmd = 4'b0111;
          4'b0001: exe_cmd = 4'b1000;
          4'b1010: begin exe_cmd = 4'b0100; wb_en = 1'b0; end
          4'b1000: begin exe_cmd = 4'b0110; wb_en = 1'b0; end
          default: begin exe_cmd = 4'b0000; wb_en = 1'b0; end
        endcase
      end
      2'b01: begin
        exe_cmd = 4'b0010;
        mem_r   = s_bit;
        mem_w   = !s_bit;
        wb_en   = s_bit;
      end
      2'b10:   br = 1'b1;
      default: ;
    endcase
  end

  logic bubble;
  assign bubble = bus.hazard || !cond_pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bus.flush) begin
      if (!rst || bus.flush) begin
        bus.PC_out        <= '0;
        bus.Val_Rn        <= '0;
        bus.Val_Rm        <= '0;
        bus.Dest          <= '0;
        bus.imm           <= 1'b0;
        bus.Shift_operand <= '0;
        bus.Signed_imm_24 <= '0;
        bus.EXE_CMD       <= '0;
        bus.MEM_R_EN      <= 1'b0;
        bus.MEM_W_EN      <= 1'b0;
        bus.WB_EN         <= 1'b0;
        bus.B             <= 1'b0;
        bus.S             <= 1'b0;
      end
    end else begin
      bus.PC_out        <= bus.PC_in;
      bus.Val_Rn        <= val_rn;
      bus.Val_Rm        <= val_rm;
      bus.Dest          <= rd;
      bus.imm           <= i_bit;
      bus.Shift_operand <= bus.Instruction_in[11:0];
      bus.Signed_imm_24 <= bus.Instruction_in[23:0];
      bus.EXE_CMD       <= bubble ? 4'b0000 : exe_cmd;
      bus.MEM_R_EN      <= !bubble && mem_r;
      bus.MEM_W_EN      <= !bubble && mem_w;
      bus.WB_EN         <= !bubble && wb_en;
      bus.B             <= !bubble && br;
      bus.S             <= !bubble && s_out;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with a queue-based scoreboard:
// the stimulus pushes hand-computed expectations, a monitor pops and checks.
module tb_decode_stage;

  logic clk;
  logic rst;
  decode_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
  } outs_t;

  typedef struct {
    int unsigned due;
    int          id;
    outs_t       exp;
  } sb_t;

  sb_t         q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic outs_t get_outs();
    outs_t o;
    o = {bus.PC_out, bus.Val_Rn, bus.Val_Rm, bus.Dest, bus.EXE_CMD, bus.MEM_R_EN,
         bus.MEM_W_EN, bus.WB_EN, bus.B, bus.S, bus.imm, bus.Shift_operand, bus.Signed_imm_24};
    return o;
  endfunction

  // Field slices (Dest, imm, shift operand, imm24) come straight from the
  // instruction word; values and controls are given by hand per vector.
  function automatic outs_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] rn, input logic [31:0] rm,
                               input logic [3:0] cmd, input logic mr, input logic mw,
                               input logic wb, input logic b, input logic s);
    outs_t o;
    o.pc   = pc;
    o.rn   = rn;
    o.rm   = rm;
    o.dest = instr[15:12];
    o.cmd  = cmd;
    o.mr   = mr;
    o.mw   = mw;
    o.wb   = wb;
    o.b    = b;
    o.s    = s;
    o.imm  = instr[25];
    o.shop = instr[11:0];
    o.simm = instr[23:0];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_outs(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic issue(input int id, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [3:0] sr, input logic hz, input logic fl,
                       input logic wen, input logic [3:0] wd, input logic [31:0] wv,
                       input outs_t e);
    sb_t t;
    @(negedge clk);
    bus.PC_in          = pc;
    bus.Instruction_in = instr;
    bus.SR             = sr;
    bus.hazard         = hz;
    bus.flush          = fl;
    bus.WB_en_in       = wen;
    bus.WB_dest        = wd;
    bus.WB_value       = wv;
    t.due = cyc + 1;
    t.id  = id;
    t.exp = e;
    q.push_back(t);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    sb_t t;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() != 0 && q[0].due <= cyc) begin
        t = q.pop_front();
        checks++;
        if (t.due != cyc) begin
          errors++;
          $display("FAIL vec%0d missed: due=%0d now=%0d", t.id, t.due, cyc);
        end else if (get_outs() !== t.exp) begin
          errors++;
          $display("FAIL vec%0d got=%h want=%h", t.id, get_outs(), t.exp);
        end
      end
    end
  end

  initial begin
    rst                = 1'b1;
    bus.PC_in          = '0;
    bus.Instruction_in = '0;
    bus.SR             = '0;
    bus.hazard         = 1'b0;
    bus.flush          = 1'b0;
    bus.WB_en_in       = 1'b0;
    bus.WB_dest        = '0;
    bus.WB_value       = '0;
    #2 rst = 1'b0;
    #1 chk_outs("reset_outs", get_outs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(1, 32'h100, 32'hE0812001, 4'h0, 0, 0, 1, 4'd1, 32'd5,
          mk(32'h100, 32'hE0812001, 32'd5, 32'd5, 4'b0010, 0, 0, 1, 0, 0));
    #1;
    chk("add_src1", {28'd0, bus.src1}, 32'd1);
    chk("add_src2", {28'd0, bus.src2}, 32'd1);
    chk("add_two_src", {31'd0, bus.Two_src}, 32'd1);
    issue(2, 32'h104, 32'hE0812001, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h104, 32'hE0812001, 32'd5, 32'd5, 4'b0010, 0, 0, 1, 0, 0));
    issue(3, 32'h108, 32'h00812001, 4'b0000, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h108, 32'h00812001, 32'd5, 32'd5, 4'b0000, 0, 0, 0, 0, 0));
    issue(4, 32'h10C, 32'h00812001, 4'b0100, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h10C, 32'h00812001, 32'd5, 32'd5, 4'b0010, 0, 0, 1, 0, 0));
    issue(5, 32'h110, 32'hE5812000, 4'h0, 0, 0, 1, 4'd2, 32'h77,
          mk(32'h110, 32'hE5812000, 32'd5, 32'h77, 4'b0010, 0, 1, 0, 0, 0));
    #1;
    chk("str_src1", {28'd0, bus.src1}, 32'd1);
    chk("str_src2", {28'd0, bus.src2}, 32'd2);
    chk("str_two_src", {31'd0, bus.Two_src}, 32'd1);
    issue(6, 32'h114, 32'hE5912000, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h114, 32'hE5912000, 32'd5, 32'd0, 4'b0010, 1, 0, 1, 0, 0));
    #1;
    chk("ldr_src2", {28'd0, bus.src2}, 32'd0);
    issue(7, 32'h118, 32'hEA000004, 4'h0, 1, 1, 1, 4'd4, 32'h44, '0);
    issue(8, 32'h11C, 32'hEA000004, 4'h0, 1, 0, 0, 4'd0, 32'd0,
          mk(32'h11C, 32'hEA000004, 32'd0, 32'h44, 4'b0000, 0, 0, 0, 0, 0));
    issue(9, 32'h120, 32'hEA000004, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h120, 32'hEA000004, 32'd0, 32'h44, 4'b0000, 0, 0, 0, 1, 0));
    issue(10, 32'h124, 32'hE08F200F, 4'h0, 0, 0, 1, 4'd15, 32'hDEAD,
          mk(32'h124, 32'hE08F200F, 32'd0, 32'd0, 4'b0010, 0, 0, 1, 0, 0));
    issue(11, 32'h128, 32'hE3B0300A, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h128, 32'hE3B0300A, 32'd0, 32'd0, 4'b0001, 0, 0, 1, 0, 1));
    #1;
    chk("mov_two_src", {31'd0, bus.Two_src}, 32'd0);
    chk("mov_src2", {28'd0, bus.src2}, 32'd10);
    issue(12, 32'h12C, 32'hE1510001, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h12C, 32'hE1510001, 32'd5, 32'd5, 4'b0100, 0, 0, 0, 0, 1));
    issue(13, 32'h130, 32'hE0612001, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h130, 32'hE0612001, 32'd5, 32'd5, 4'b0000, 0, 0, 0, 0, 0));
    issue(14, 32'h134, 32'hEC000000, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h134, 32'hEC000000, 32'd0, 32'd0, 4'b0000, 0, 0, 0, 0, 0));
    issue(15, 32'h138, 32'hC0212001, 4'b0000, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h138, 32'hC0212001, 32'd5, 32'd5, 4'b1000, 0, 0, 1, 0, 0));
    issue(16, 32'h13C, 32'hC0212001, 4'b1000, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h13C, 32'hC0212001, 32'd5, 32'd5, 4'b0000, 0, 0, 0, 0, 0));
    issue(17, 32'h140, 32'hE0855005, 4'h0, 1, 0, 1, 4'd5, 32'h55,
          mk(32'h140, 32'hE0855005, 32'h55, 32'h55, 4'b0000, 0, 0, 0, 0, 0));
    issue(18, 32'h144, 32'hE5912000, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h144, 32'hE5912000, 32'd5, 32'd0, 4'b0010, 1, 0, 1, 0, 0));

    // Asynchronous reset mid-cycle while the LDR (WB_EN=1) is registered.
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_outs("midreset_outs", get_outs(), '0);
    @(posedge clk);
    #1 chk_outs("held_reset_outs", get_outs(), '0);
    @(negedge clk);
    rst = 1'b1;

    issue(19, 32'h200, 32'hE0812001, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h200, 32'hE0812001, 32'd0, 32'd0, 4'b0010, 0, 0, 1, 0, 0));
    issue(20, 32'h204, 32'hE0842004, 4'h0, 0, 0, 0, 4'd0, 32'd0,
          mk(32'h204, 32'hE0842004, 32'd0, 32'd0, 4'b0010, 0, 0, 1, 0, 0));

    repeat (20) if (q.size() != 0) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 PC_in  input  32  PC of the fetched instruction, from the fetch pipeline register.
REQ-005 Instruction_in  input  32  fetched ARM instruction.
REQ-006 SR  input  4  status flags {N,Z,C,V}.
REQ-007 hazard  input  1  stall request from the hazard unit.
REQ-008 flush  input  1  branch-taken flush.
REQ-009 WB_en_in  input  1  write-back enable.
REQ-010 WB_dest  input  4  write-back register index.
REQ-011 WB_value  input  32  write-back data.
REQ-012 src1, src2  output  4 each  combinational source indices for the hazard unit.
REQ-013 Two_src  output  1  combinational; instruction reads a second register.
REQ-014 Registered outputs SHALL be:
- PC_out 32
- Val_Rn 32, Val_Rm 32
- Dest 4
- EXE_CMD 4
- MEM_R_EN, MEM_W_EN, WB_EN, B, S, imm (1 each)
- Shift_operand 12
- Signed_imm_24 24

Function
REQ-015 Register file: 15 x 32-bit (R0-R14); written at the clock edge when WB_en_in=1 and WB_dest!=15; WB_dest=15 is ignored.
REQ-016 Register reads SHALL be combinational, with write-bypass: a read index equal to WB_dest while WB_en_in=1 returns WB_value; index 15 reads 0.
REQ-017 Instruction field decode:
- cond = [31:28]
- mode = [27:26]
- I = [25]
- opcode = [24:21]
- S bit = [20]
- Rn = [19:16]
- Rd = [15:12]
- Shift_operand = [11:0]
- Signed_imm_24 = [23:0]
REQ-018 src1 SHALL equal Rn; src2 SHALL be Rd when mode=01 and S bit=0 (STR), otherwise [3:0].
REQ-019 Two_src SHALL be (~I) OR (STR).
REQ-020 Condition check SHALL follow ARM cond codes 0000-1101; 1110 always passes; 1111 always fails.
REQ-021 Data processing (mode=00) opcode -> EXE_CMD:
- MOV 1101->0001, MVN 1111->1001
- ADD 0100->0010, ADC 0101->0011
- SUB 0010->0100, SBC 0110->0101
- AND 0000->0110, ORR 1100->0111, EOR 0001->1000
- CMP 1010->0100, TST 1000->0110
- any other opcode -> EXE_CMD 0000, WB_EN=0.
REQ-022 WB_EN=1 for every data-processing opcode listed in REQ-021 except CMP and TST.
REQ-023 Memory (mode=01): EXE_CMD=0010; S bit=1 -> LDR (MEM_R_EN=1, WB_EN=1); S bit=0 -> STR (MEM_W_EN=1).
REQ-024 Branch (mode=10): B=1, all other controls 0; mode=11 -> all controls 0.
REQ-025 Output S SHALL carry the S bit for mode=00 only, else 0; imm SHALL carry I.
REQ-026 Latency: all registered outputs SHALL reflect the decode of Instruction_in exactly one cycle after it is presented.
REQ-027 Bubble: when hazard=1 or condition fails, the next edge SHALL load EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B and S as 0; data fields load normally.
REQ-028 Flush: flush=1 SHALL load all registered outputs as 0; flush takes priority over hazard and decode.
REQ-029 A register-file write and a bubble or flush in the same cycle SHALL still perform the write.

Reset
REQ-030 rst=0 SHALL immediately clear all 15 registers and all registered outputs to 0, independent of clk, including mid-stream.
REQ-031 On rst release, operation SHALL begin at the first rising edge with rst=1.

Verification
REQ-032 Reset mid-operation:
- drive rst=0 while WB_EN=1 is registered -> all outputs and R0-R14 read 0 immediately.
REQ-033 ADD with write-back forwarding:
- write R1=5 (WB_en_in=1, WB_dest=1); same cycle Instruction_in=0xE0812001 (ADD R2,R1,R1)
- -> next cycle Val_Rn=5, Val_Rm=5, EXE_CMD=0010, Dest=2, WB_EN=1.
REQ-034 Condition fail:
- Instruction_in=0x00812001 (EQ), SR=0000 -> next cycle EXE_CMD=0, WB_EN=0.
- Same instruction with SR=0100 -> WB_EN=1.
REQ-035 STR and LDR:
- 0xE5812000 (STR) -> src2=2, Two_src=1, MEM_W_EN=1, WB_EN=0.
- 0xE5912000 (LDR) -> MEM_R_EN=1, WB_EN=1.
REQ-036 Priority:
- hazard=1 and flush=1 together on a B instruction (0xEA000004) -> all outputs 0.
- hazard=1 alone -> B=0, Signed_imm_24=0x000004.
REQ-037 R15 write guard:
- write with WB_dest=15 -> no register changes; Rn=15 reads 0.
